// File: rtl/reg_bus_ctrl.sv
// Register-bus move sequencer: arbitrates move requests, enables one source onto the
// shared bus, then pulses the destination write enable. Define REG_BUS_RR_EN for round-robin arbitration.
module reg_bus_ctrl #(
  parameter int unsigned NUM_REGS = 8,
  parameter int unsigned NUM_REQ  = 4,
  parameter int unsigned IDX_W    = 3
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*IDX_W-1:0] src_idx,
  input  logic [NUM_REQ*IDX_W-1:0] dst_idx,
  output logic [NUM_REGS-1:0]      rd_hiz,
  output logic [NUM_REGS-1:0]      wr_en,
  output logic [NUM_REQ-1:0]       ack,
  output logic                     err,
  output logic                     busy
);

  localparam int unsigned REQ_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {IDLE, DRIVE, WRITE, DONE} state_e;

  state_e              state_q, state_d;
  logic [REQ_W-1:0]    win_q, win_d;
  logic [IDX_W-1:0]    src_q, src_d;
  logic [IDX_W-1:0]    dst_q, dst_d;
  logic                bad_q, bad_d;
  logic [NUM_REGS-1:0] rd_hiz_q, rd_hiz_d;
  logic [NUM_REGS-1:0] wr_en_q, wr_en_d;
  logic [NUM_REQ-1:0]  ack_q, ack_d;
  logic                err_q, err_d;
  logic                busy_q, busy_d;

  logic [REQ_W-1:0]    pick_c;
  logic [IDX_W-1:0]    src_sel_c;
  logic [IDX_W-1:0]    dst_sel_c;

`ifdef REG_BUS_RR_EN
  logic [REQ_W-1:0] last_q, last_d;
  logic [REQ_W-1:0] cand_c;
  logic             found_c;

  // Round-robin: first set request at or after last+1, wrapping.
  always_comb begin
    pick_c  = '0;
    cand_c  = '0;
    found_c = 1'b0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      cand_c = REQ_W'((32'(last_q) + k) % NUM_REQ);
      if (!found_c && req[cand_c]) begin
        pick_c  = cand_c;
        found_c = 1'b1;
      end
    end
  end
`else
  // Fixed priority: lowest requester index wins.
  always_comb begin
    pick_c = '0;
    for (int i = int'(NUM_REQ) - 1; i >= 0; i--) begin
      if (req[i]) pick_c = REQ_W'(i);
    end
  end
`endif

  always_comb begin
    src_sel_c = '0;
    dst_sel_c = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (32'(pick_c) == i) begin
        src_sel_c = src_idx[i*IDX_W +: IDX_W];
        dst_sel_c = dst_idx[i*IDX_W +: IDX_W];
      end
    end
  end

  // Next state, then outputs decoded from the next state and latched indices.
  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    src_d   = src_q;
    dst_d   = dst_q;
    bad_d   = bad_q;
`ifdef REG_BUS_RR_EN
    last_d  = last_q;
`endif
    case (state_q)
      IDLE: begin
        if (|req) begin
          win_d = pick_c;
          src_d = src_sel_c;
          dst_d = dst_sel_c;
          bad_d = (32'(src_sel_c) >= NUM_REGS) || (32'(dst_sel_c) >= NUM_REGS);
          // Out-of-range and self-moves complete without touching the bus.
          if (bad_d || (src_sel_c == dst_sel_c)) state_d = DONE;
          else                                   state_d = DRIVE;
        end
      end
      DRIVE: state_d = WRITE;
      WRITE: state_d = DONE;
      DONE: begin
        state_d = IDLE;
`ifdef REG_BUS_RR_EN
        last_d  = win_q;
`endif
      end
      default: state_d = IDLE;
    endcase

    rd_hiz_d = '1;
    wr_en_d  = '0;
    ack_d    = '0;
    err_d    = (state_d == DONE) && bad_d;
    busy_d   = (state_d != IDLE);
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      if (((state_d == DRIVE) || (state_d == WRITE)) && (32'(src_d) == i)) rd_hiz_d[i] = 1'b0;
      if ((state_d == WRITE) && (32'(dst_d) == i))                         wr_en_d[i]  = 1'b1;
    end
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if ((state_d == DONE) && (32'(win_d) == i)) ack_d[i] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      win_q    <= '0;
      src_q    <= '0;
      dst_q    <= '0;
      bad_q    <= 1'b0;
      rd_hiz_q <= '1;
      wr_en_q  <= '0;
      ack_q    <= '0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      win_q    <= win_d;
      src_q    <= src_d;
      dst_q    <= dst_d;
      bad_q    <= bad_d;
      rd_hiz_q <= rd_hiz_d;
      wr_en_q  <= wr_en_d;
      ack_q    <= ack_d;
      err_q    <= err_d;
      busy_q   <= busy_d;
    end
  end

`ifdef REG_BUS_RR_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) last_q <= REQ_W'(NUM_REQ - 1);
    else        last_q <= last_d;
  end
`endif

  assign rd_hiz = rd_hiz_q;
  assign wr_en  = wr_en_q;
  assign ack    = ack_q;
  assign err    = err_q;
  assign busy   = busy_q;

endmodule

// File: tb/tb_reg_bus_ctrl.sv
// Bench for reg_bus_ctrl: directed moves plus random traffic against a transaction-level
// model that turns each grant into a schedule of expected per-cycle outputs.
module tb_reg_bus_ctrl;

  localparam int unsigned NREGS = 6;
  localparam int unsigned NREQ  = 4;
  localparam int unsigned IW    = 3;

  logic                 clk;
  logic                 reset;
  logic [NREQ-1:0]      req;
  logic [NREQ*IW-1:0]   src_idx;
  logic [NREQ*IW-1:0]   dst_idx;
  logic [NREGS-1:0]     rd_hiz;
  logic [NREGS-1:0]     wr_en;
  logic [NREQ-1:0]      ack;
  logic                 err;
  logic                 busy;

  reg_bus_ctrl #(.NUM_REGS(NREGS), .NUM_REQ(NREQ), .IDX_W(IW)) dut (
    .clk(clk), .reset(reset), .req(req), .src_idx(src_idx), .dst_idx(dst_idx),
    .rd_hiz(rd_hiz), .wr_en(wr_en), .ack(ack), .err(err), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [NREGS-1:0] rd_hiz;
    logic [NREGS-1:0] wr_en;
    logic [NREQ-1:0]  ack;
    logic             err;
    logic             busy;
  } snap_t;

  snap_t           exp_q[$];
  int              n_vec = 0;
  int              n_err = 0;
  int              last_m = NREQ - 1;
  int              granted = -1;
  logic [NREQ-1:0] acked = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic snap_t quiet();
    snap_t x;
    x.rd_hiz = '1;
    x.wr_en  = '0;
    x.ack    = '0;
    x.err    = 1'b0;
    x.busy   = 1'b0;
    return x;
  endfunction

  function automatic int pick_m(input logic [NREQ-1:0] r);
`ifdef REG_BUS_RR_EN
    for (int k = 1; k <= int'(NREQ); k++)
      if (r[(last_m + k) % NREQ]) return (last_m + k) % NREQ;
`else
    for (int i = 0; i < int'(NREQ); i++)
      if (r[i]) return i;
`endif
    return -1;
  endfunction

  // Turn a grant into the expected output for each following cycle.
  task automatic plan();
    int    w;
    int    s;
    int    d;
    snap_t x;
    w = pick_m(req);
    if (w < 0) return;
    s = int'(src_idx[w*IW +: IW]);
    d = int'(dst_idx[w*IW +: IW]);
    last_m  = w;
    granted = w;
    x = quiet();
    x.busy = 1'b1;
    if (s >= int'(NREGS) || d >= int'(NREGS)) begin
      x.ack[w] = 1'b1;
      x.err    = 1'b1;
      exp_q.push_back(x);
    end else if (s == d) begin
      x.ack[w] = 1'b1;
      exp_q.push_back(x);
    end else begin
      x.rd_hiz[s] = 1'b0;
      exp_q.push_back(x);
      x.wr_en[d] = 1'b1;
      exp_q.push_back(x);
      x = quiet();
      x.busy   = 1'b1;
      x.ack[w] = 1'b1;
      exp_q.push_back(x);
    end
    exp_q.push_back(quiet());
  endtask

  task automatic cycle();
    snap_t e;
    if (exp_q.size() == 0) plan();
    @(posedge clk);
    #1;
    e = (exp_q.size() != 0) ? exp_q.pop_front() : quiet();
    check("rd_hiz", 32'(rd_hiz), 32'(e.rd_hiz));
    check("wr_en",  32'(wr_en),  32'(e.wr_en));
    check("ack",    32'(ack),    32'(e.ack));
    check("err",    32'(err),    32'(e.err));
    check("busy",   32'(busy),   32'(e.busy));
    acked = e.ack;
    if (e.ack != '0) granted = -1;
  endtask

  task automatic apply_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
    req   = '0;
    exp_q.delete();
    last_m  = NREQ - 1;
    granted = -1;
    acked   = '0;
    #2;
    check("rst_rd_hiz", 32'(rd_hiz), 32'(6'h3F));
    check("rst_wr_en",  32'(wr_en),  32'h0);
    check("rst_ack",    32'(ack),    32'h0);
    check("rst_err",    32'(err),    32'h0);
    check("rst_busy",   32'(busy),   32'h0);
    @(negedge clk);
    reset = 1'b1;
  endtask

  // Bus-exclusion invariants, checked every cycle out of reset.
  always @(negedge clk) begin
    if (reset) begin
      check("one_driver", 32'($countones(~rd_hiz) <= 1), 32'h1);
      check("one_writer", 32'($countones(wr_en) <= 1), 32'h1);
      if (wr_en != '0) check("wr_has_src", 32'(rd_hiz != '1), 32'h1);
    end
  end

  initial begin
    int got_ord[$];
    int exp_ord[5];
    reset   = 1'b0;
    req     = '0;
    src_idx = '0;
    dst_idx = '0;

    // Real move 2 -> 5 by requester 0.
    apply_reset();
    src_idx[0 +: IW] = 3'd2;
    dst_idx[0 +: IW] = 3'd5;
    req = 4'b0001;
    cycle();
    check("drive_src2", 32'(rd_hiz), 32'(6'b111011));
    check("drive_no_wr", 32'(wr_en), 32'h0);
    req = '0;
    src_idx[0 +: IW] = 3'd1;
    cycle();
    check("write_src2", 32'(rd_hiz), 32'(6'b111011));
    check("write_dst5", 32'(wr_en), 32'(6'b100000));
    cycle();
    check("done_ack0", 32'(ack), 32'h1);
    check("done_hiz", 32'(rd_hiz), 32'(6'h3F));
    cycle();

    // Self-move is a no-op acked one cycle after grant.
    src_idx[1*IW +: IW] = 3'd3;
    dst_idx[1*IW +: IW] = 3'd3;
    req = 4'b0010;
    cycle();
    check("noop_ack1", 32'(ack), 32'h2);
    check("noop_err", 32'(err), 32'h0);
    req = '0;
    cycle();

    // Source index beyond NREGS reports an error without bus activity.
    src_idx[2*IW +: IW] = 3'd7;
    dst_idx[2*IW +: IW] = 3'd1;
    req = 4'b0100;
    cycle();
    check("oor_ack2", 32'(ack), 32'h4);
    check("oor_err", 32'(err), 32'h1);
    req = '0;
    cycle();

    // All requesters held continuously: observe grant order.
    apply_reset();
    for (int i = 0; i < int'(NREQ); i++) begin
      src_idx[i*IW +: IW] = IW'(i);
      dst_idx[i*IW +: IW] = IW'(i + 1);
    end
    req = 4'b1111;
    for (int c = 0; c < 24; c++) begin
      cycle();
      for (int i = 0; i < int'(NREQ); i++) if (ack[i]) got_ord.push_back(i);
    end
`ifdef REG_BUS_RR_EN
    exp_ord = '{0, 1, 2, 3, 0};
`else
    exp_ord = '{0, 0, 0, 0, 0};
`endif
    for (int k = 0; k < 5; k++)
      check("arb_order", 32'((k < got_ord.size()) ? got_ord[k] : -1), 32'(exp_ord[k]));
    req = '0;
    repeat (6) cycle();

    // Reset during WRITE aborts the move at once, with no ack afterwards.
    apply_reset();
    src_idx[0 +: IW] = 3'd0;
    dst_idx[0 +: IW] = 3'd4;
    req = 4'b0001;
    cycle();
    req = '0;
    cycle();
    check("pre_abort_wr", 32'(wr_en), 32'(6'b010000));
    #2;
    reset = 1'b0;
    #1;
    check("abort_hiz", 32'(rd_hiz), 32'(6'h3F));
    check("abort_wr", 32'(wr_en), 32'h0);
    check("abort_busy", 32'(busy), 32'h0);
    exp_q.delete();
    last_m  = NREQ - 1;
    granted = -1;
    @(negedge clk);
    reset = 1'b1;
    repeat (4) cycle();

    // Random traffic, including drops, holds after ack and post-grant index changes.
    apply_reset();
    for (int c = 0; c < 600; c++) begin
      cycle();
      for (int i = 0; i < int'(NREQ); i++) begin
        if (acked[i]) begin
          if ($urandom_range(1) == 0) req[i] = 1'b0;
        end else if (req[i] && granted != i && $urandom_range(19) == 0) begin
          req[i] = 1'b0;
        end else if (!req[i] && $urandom_range(3) == 0) begin
          req[i] = 1'b1;
          src_idx[i*IW +: IW] = IW'($urandom_range(7));
          dst_idx[i*IW +: IW] = ($urandom_range(3) == 0) ? src_idx[i*IW +: IW]
                                                         : IW'($urandom_range(7));
        end
        if (granted == i) begin
          src_idx[i*IW +: IW] = IW'($urandom_range(7));
          dst_idx[i*IW +: IW] = IW'($urandom_range(7));
        end
      end
    end
    req = '0;
    repeat (8) cycle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/reg_bus_ctrl.md
Name: reg_bus_ctrl

Overview:
- Sequences register-to-register moves over the shared 32-bit tri-state register bus.
- Arbitrates move requests from up to NUM_REQ requesters, for example decode, writeback and debug.
- For each granted move it enables exactly one source register onto the bus, then pulses the write enable of the destination register.
- Sits between the control unit and the register bank; it never touches bus data itself.

Parameters:
- NUM_REGS, 8, number of registers on the bus.
- NUM_REQ, 4, number of requesters.
- IDX_W, 3, register index width; must be at least clog2(NUM_REGS).

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- req  input  NUM_REQ  move request per requester; held high until ack.
- src_idx  input  NUM_REQ*IDX_W  source index; requester i uses bits [i*IDX_W +: IDX_W].
- dst_idx  input  NUM_REQ*IDX_W  destination index, packed the same way.
- rd_hiz  output  NUM_REGS  per-register output control; 1 = output high-Z, 0 = drive bus.
- wr_en  output  NUM_REGS  per-register write enable.
- ack  output  NUM_REQ  one-cycle completion pulse to the granted requester.
- err  output  1  valid with ack; 1 = index out of range, nothing moved.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; rd_hiz all 1; wr_en, ack, err, busy all 0; round-robin pointer last=NUM_REQ-1.
- Reset asserted mid-move aborts the move immediately. No wr_en pulse is issued and no ack is issued.
- States: IDLE, DRIVE, WRITE, DONE.
- IDLE:
  - If any req is high, pick winner w, register w, src_idx[w] and dst_idx[w], and go to DRIVE.
  - If src>=NUM_REGS or dst>=NUM_REGS, latch err=1 and go to DONE.
  - If src==dst, go to DONE with err=0 (no-op; no bus drive, no write).
- DRIVE (1 cycle): rd_hiz[src]=0 so the bus settles; wr_en all 0. Next state WRITE.
- WRITE (1 cycle): rd_hiz[src]=0 and wr_en[dst]=1. The destination captures on the edge that ends WRITE. Next state DONE.
- DONE (1 cycle): rd_hiz all 1; ack[w]=1; err valid; round-robin pointer last=w. Next state IDLE.
- Outputs are registered, decoded from state and the latched indices only.
- Bus-exclusion invariants:
  - At most one rd_hiz bit is 0 in any cycle.
  - At most one wr_en bit is 1 in any cycle.
  - A wr_en pulse never occurs without the matching source driving in the same cycle.
- Latency: a request seen high in IDLE at edge N gives ack high during cycle N+3 for a real move. Back-to-back throughput is one move per 4 cycles.
- Requester changes to req, src_idx or dst_idx after the grant edge are ignored until DONE.
- A requester still holding req in the IDLE cycle after its ack counts as a new request.
- A requester that deasserts req before being granted is simply not granted; no state is kept for it.

Optional Feature:
- Macro REG_BUS_RR_EN.
- Defined: round-robin arbitration. Search starts at requester (last+1) mod NUM_REQ and takes the first req bit set.
- Undefined: fixed priority, lowest requester index wins; the last pointer is not implemented.

Test Plan:
- Reset, then req[0]=1 with src=2, dst=5:
  - rd_hiz[2]=0 during DRIVE and WRITE.
  - wr_en=8'b0010_0000 during WRITE only.
  - ack=4'b0001 three cycles after the grant edge.
  - rd_hiz returns to 8'hFF in DONE.
- req[1] with src=3, dst=3: ack[1] pulses one cycle after the grant edge; rd_hiz stays 8'hFF; wr_en stays 0; err=0.
- NUM_REGS=6, req[2] with src=7: err=1 together with ack[2]; no rd_hiz or wr_en activity.
- req=4'b1111 held continuously:
  - With REG_BUS_RR_EN, acks occur in order 0,1,2,3,0 at 4-cycle spacing.
  - Without it, only requester 0 is acked repeatedly.
- Assert reset during WRITE: on the same edge rd_hiz becomes 8'hFF, wr_en 0 and busy 0; no ack follows.
- Random move traffic: assertion checks that at most one rd_hiz bit is 0 and at most one wr_en bit is 1 in every cycle.
